bit_serial_mvm: RTL and testbench

Parametrised bit-serial matrix-vector multiplier. It computes result[o] = sum over i of coeff[o][i] * values[i] for N_OUT outputs and N_IN inputs. It processes one bit-plane of all input values per clock, MSB first, shift-accumulating into N_OUT accumulators. It generalises the fixed 10-in/15-out multiplier to runtime-loaded coefficients, signed/unsigned mode, a ready/start/done handshake and configurable widths.

---
 rtl/bsmm_pkg.sv | 19 +
 rtl/bit_serial_mvm_if.sv | 24 ++
 rtl/bsmm_row_acc.sv | 45 ++++
 rtl/bit_serial_mvm.sv | 143 ++++++++++++++
 tb/tb_bit_serial_mvm.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsmm_pkg.sv
// Shared types and sizing helpers for the bit-serial matrix-vector multiplier.
package bsmm_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    // Wide enough that a full dot product can never overflow the accumulator.
    function automatic int acc_width(input int width, input int cw, input int n_in);
        return width + cw + clog2(n_in);
    endfunction

endpackage

// File: rtl/bit_serial_mvm_if.sv
// Request/response bundle of bit_serial_mvm; BSMM_SATURATE_EN adds the per-channel sat flags.
interface bit_serial_mvm_if #(
    parameter int N_IN  = 10,
    parameter int N_OUT = 15,
    parameter int WIDTH = 32,
    parameter int CW    = 8,
    parameter int RES_W = 32
);
    logic                               start;
    logic                               ready;
    logic                               done;
    logic [N_IN-1:0][WIDTH-1:0]         values;
    logic [N_OUT-1:0][N_IN-1:0][CW-1:0] coeff;
    logic [N_OUT-1:0][RES_W-1:0]        result;
`ifdef BSMM_SATURATE_EN
    logic [N_OUT-1:0]                   sat;

    modport master (output start, values, coeff, input ready, done, result, sat);
    modport slave  (input start, values, coeff, output ready, done, result, sat);
`else
    modport master (output start, values, coeff, input ready, done, result);
    modport slave  (input start, values, coeff, output ready, done, result);
`endif
endinterface

// File: rtl/bsmm_row_acc.sv
// One output channel: shadow coefficient row, bit-plane partial sum and shift-accumulate.
module bsmm_row_acc
    import bsmm_pkg::*;
#(
    parameter int N_IN  = 10,
    parameter int CW    = 8,
    parameter int ACC_W = 44
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic                     i_clr,
    input  logic                     i_run,
    input  logic                     i_neg,
    input  logic [N_IN-1:0][CW-1:0]  i_coeff,
    input  logic [N_IN-1:0]          i_bits,
    output logic [ACC_W-1:0]         o_acc
);
    logic [N_IN-1:0][CW-1:0] r_coeff;
    logic [ACC_W-1:0]        r_acc;
    logic [ACC_W-1:0]        w_partial;

    always_comb begin
        w_partial = '0;
        for (int i = 0; i < N_IN; i++)
            if (i_bits[i]) w_partial = w_partial + ACC_W'($signed(r_coeff[i]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_coeff <= '0;
            r_acc   <= '0;
        end else begin
            if (i_load) r_coeff <= i_coeff;
            if (i_clr)
                r_acc <= '0;
            else if (i_run)
                // The MSB plane of a two's complement value carries negative weight.
                r_acc <= i_neg ? (r_acc << 1) - w_partial : (r_acc << 1) + w_partial;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/bit_serial_mvm.sv
// Bit-serial matrix-vector multiplier: one bit-plane of all inputs per clock, MSB first.
// Define BSMM_SATURATE_EN to clamp results to the signed RES_W range and drive sat flags.
module bit_serial_mvm
    import bsmm_pkg::*;
#(
    parameter int N_IN   = 10,
    parameter int N_OUT  = 15,
    parameter int WIDTH  = 32,
    parameter int CW     = 8,
    parameter int RES_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic            clk,
    input  logic            rst,
    bit_serial_mvm_if.slave io_bus
);
    localparam int ACC_W = acc_width(WIDTH, CW, N_IN);
    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    state_t                      r_state;
    logic                        r_ready;
    logic                        r_done;
    logic [CNT_W-1:0]            r_cnt;
    logic [N_IN-1:0][WIDTH-1:0]  r_values;
    logic [N_OUT-1:0][RES_W-1:0] r_result;
    logic [N_OUT-1:0][RES_W-1:0] w_res;
    logic [N_IN-1:0]             w_bits;
    logic                        w_accept;
    logic                        w_clr;
    logic                        w_run;
    logic                        w_neg;

    assign w_accept = io_bus.start & r_ready;
    assign w_clr    = (r_state == LOAD);
    assign w_run    = (r_state == RUN);
    assign w_neg    = (SIGNED != 0) && w_run && (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // Outputs register out of DONE, so done lands one cycle after that state.
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: if (io_bus.start) begin
                    r_state <= LOAD;
                    r_ready <= 1'b0;
                end
                LOAD: begin
                    r_state <= RUN;
                    r_cnt   <= CNT_W'(WIDTH - 1);
                end
                RUN: if (r_cnt == '0) begin
                    r_state <= DONE;
                    r_ready <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                DONE: if (io_bus.start) begin
                    r_state <= LOAD;
                    r_ready <= 1'b0;
                end else begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)           r_values <= '0;
        else if (w_accept) r_values <= io_bus.values;
    end

    always_comb begin
        w_bits = '0;
        for (int i = 0; i < N_IN; i++) w_bits[i] = r_values[i][r_cnt];
    end

`ifdef BSMM_SATURATE_EN
    logic [N_OUT-1:0] w_sat;
    logic [N_OUT-1:0] r_sat;
`endif

    for (genvar o = 0; o < N_OUT; o++) begin : g_row
        logic [ACC_W-1:0] w_acc;

        bsmm_row_acc #(.N_IN(N_IN), .CW(CW), .ACC_W(ACC_W)) u_row (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_accept),
            .i_clr   (w_clr),
            .i_run   (w_run),
            .i_neg   (w_neg),
            .i_coeff (io_bus.coeff[o]),
            .i_bits  (w_bits),
            .o_acc   (w_acc)
        );

        if (RES_W >= ACC_W) begin : g_ext
            assign w_res[o] = RES_W'($signed(w_acc));
`ifdef BSMM_SATURATE_EN
            assign w_sat[o] = 1'b0;
`endif
        end else begin : g_cut
`ifdef BSMM_SATURATE_EN
            // Out of range whenever the bits above the RES_W sign bit disagree with it.
            logic [ACC_W-RES_W:0] w_top;
            logic                 w_ovf;
            assign w_top    = w_acc[ACC_W-1:RES_W-1];
            assign w_ovf    = !((&w_top) || !(|w_top));
            assign w_sat[o] = w_ovf;
            assign w_res[o] = w_ovf ? {w_acc[ACC_W-1], {(RES_W-1){~w_acc[ACC_W-1]}}}
                                    : w_acc[RES_W-1:0];
`else
            logic w_unused_hi;
            assign w_unused_hi = ^w_acc[ACC_W-1:RES_W];
            assign w_res[o]    = w_acc[RES_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                    r_result <= '0;
        else if (r_state == DONE)   r_result <= w_res;
    end

`ifdef BSMM_SATURATE_EN
    always_ff @(posedge clk) begin
        if (rst)                    r_sat <= '0;
        else if (r_state == DONE)   r_sat <= w_sat;
    end
    assign io_bus.sat = r_sat;
`endif

    assign io_bus.ready  = r_ready;
    assign io_bus.done   = r_done;
    assign io_bus.result = r_result;

endmodule

// File: tb/tb_bit_serial_mvm.sv
// Bench for bit_serial_mvm: signed and unsigned instances share stimulus, checked per cycle.
module tb_bit_serial_mvm;
    localparam int N_IN  = 10;
    localparam int N_OUT = 15;
    localparam int WIDTH = 32;
    localparam int CW    = 8;
    localparam int RES_W = 32;
    localparam longint MAXV = (longint'(1) <<< (RES_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (RES_W - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                               t_start = 1'b0;
    logic [N_IN-1:0][WIDTH-1:0]         t_val   = '0;
    logic [N_OUT-1:0][N_IN-1:0][CW-1:0] t_coef  = '0;

    bit_serial_mvm_if #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .CW(CW), .RES_W(RES_W)) bus_s ();
    bit_serial_mvm_if #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .CW(CW), .RES_W(RES_W)) bus_u ();

    assign bus_s.start  = t_start;
    assign bus_s.values = t_val;
    assign bus_s.coeff  = t_coef;
    assign bus_u.start  = t_start;
    assign bus_u.values = t_val;
    assign bus_u.coeff  = t_coef;

    bit_serial_mvm #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .CW(CW), .RES_W(RES_W), .SIGNED(1))
        u_dut_s (.clk(clk), .rst(rst), .io_bus(bus_s));
    bit_serial_mvm #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .CW(CW), .RES_W(RES_W), .SIGNED(0))
        u_dut_u (.clk(clk), .rst(rst), .io_bus(bus_u));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: index 0 = signed instance, 1 = unsigned instance.
    bit                          m_active = 1'b0;
    int                          m_ph     = 0;
    bit                          m_done   = 1'b0;
    logic [N_OUT-1:0][RES_W-1:0] m_res  [2];
    logic [N_OUT-1:0][RES_W-1:0] m_pend [2];
    logic [N_OUT-1:0]            m_sat  [2];
    logic [N_OUT-1:0]            m_psat [2];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_res(input string name, input logic [N_OUT-1:0][RES_W-1:0] got,
                           input logic [N_OUT-1:0][RES_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            for (int o = 0; o < N_OUT; o++)
                if (got[o] !== exp[o]) begin
                    $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h (t=%0t)", name, o, got[o], exp[o], $time);
                    break;
                end
        end
    endtask

    // Plain dot product on 64-bit integers, then wrap or clamp to RES_W.
    function automatic void ref_chan(input int o, input bit sgn,
                                     output logic [RES_W-1:0] r, output logic s);
        longint acc, v;
        acc = 0;
        for (int i = 0; i < N_IN; i++) begin
            if (sgn) v = longint'($signed(t_val[i]));
            else     v = longint'({32'b0, t_val[i]});
            acc += longint'($signed(t_coef[o][i])) * v;
        end
        s = 1'b0;
`ifdef BSMM_SATURATE_EN
        if (acc > MAXV)      begin acc = MAXV; s = 1'b1; end
        else if (acc < MINV) begin acc = MINV; s = 1'b1; end
`endif
        r = acc[RES_W-1:0];
    endfunction

    always @(posedge clk) begin : p_model
        bit rdy, fin;
        if (rst) begin
            m_active = 1'b0; m_ph = 0; m_done = 1'b0;
            for (int d = 0; d < 2; d++) begin m_res[d] = '0; m_sat[d] = '0; end
        end else begin
            rdy    = !m_active || (m_ph == WIDTH + 1);
            fin    = m_active && (m_ph == WIDTH + 1);
            m_done = fin;
            if (fin) begin m_res = m_pend; m_sat = m_psat; end
            if (m_active) begin
                m_ph++;
                if (m_ph > WIDTH + 1) m_active = 1'b0;
            end
            if (t_start && rdy) begin
                m_active = 1'b1; m_ph = 0;
                for (int d = 0; d < 2; d++)
                    for (int o = 0; o < N_OUT; o++) ref_chan(o, d == 0, m_pend[d][o], m_psat[d][o]);
            end
        end
    end

    always @(negedge clk) begin : p_cmp
        logic exp_rdy;
        if (chk_en) begin
            exp_rdy = !m_active || (m_ph == WIDTH + 1);
            chk("ready_s", bus_s.ready, exp_rdy);
            chk("ready_u", bus_u.ready, exp_rdy);
            chk("done_s", bus_s.done, m_done);
            chk("done_u", bus_u.done, m_done);
            chk_res("result_s", bus_s.result, m_res[0]);
            chk_res("result_u", bus_u.result, m_res[1]);
`ifdef BSMM_SATURATE_EN
            chk("sat_s", bus_s.sat, m_sat[0]);
            chk("sat_u", bus_u.sat, m_sat[1]);
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold start until ready is seen; returns on the negedge after the accepting edge.
    task automatic issue();
        int guard;
        guard   = 0;
        t_start = 1'b1;
        while (!bus_s.ready && guard < 200) begin @(negedge clk); guard++; end
        if (guard >= 200) chk("issue_timeout", 1, 0);
        @(negedge clk);
        t_start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus_s.done && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("done_timeout", 1, 0);
    endtask

    task automatic rand_in();
        for (int i = 0; i < N_IN; i++)
            case ($urandom_range(0, 4))
                0:       t_val[i] = 32'h8000_0000;
                1:       t_val[i] = 32'hFFFF_FFFF;
                2:       t_val[i] = WIDTH'($urandom_range(0, 255));
                default: t_val[i] = WIDTH'($urandom);
            endcase
        for (int o = 0; o < N_OUT; o++)
            for (int i = 0; i < N_IN; i++)
                t_coef[o][i] = ($urandom_range(0, 7) == 0) ? 8'h80 : CW'($urandom);
    endtask

    initial begin : p_stim
        int               n;
        int               vals [N_IN] = '{1, 3, 5, 19, 24, 12, 23, 135, -23, 20};
        logic [RES_W-1:0] pr;
        logic             ps;

        // Reset held 3 cycles with start asserted: must be ignored.
        rand_in();
        t_start = 1'b1;
        @(posedge clk); #1 chk_en = 1'b1;
        cyc(3);
        rst = 1'b0; t_start = 1'b0;
        chk("rst_ready", bus_s.ready, 1);
        chk("rst_done", bus_s.done, 0);
        chk("rst_result0", bus_s.result[0], 0);
        cyc(3);
        chk("rst_idle_ready", bus_s.ready, 1);

        // Signed sum with literal expectations.
        t_val = '0; t_coef = '0;
        for (int i = 0; i < N_IN; i++) begin t_val[i] = WIDTH'(vals[i]); t_coef[0][i] = 8'd1; end
        t_coef[2][7] = 8'd1;
        ref_chan(0, 1'b1, pr, ps);
        chk("model_sum0", pr, 219);
        issue();
        wait_done(n);
        chk("latency", n, WIDTH + 2);
        chk("sum_r0", bus_s.result[0], 219);
        chk("sum_r1", bus_s.result[1], 0);
        chk("sum_r2", bus_s.result[2], 135);
        cyc(2);

        // Negative extremes: (-2^31) * (-128) = 2^38.
        t_val = '0; t_coef = '0;
        t_val[0] = 32'h8000_0000; t_coef[0][0] = 8'h80;
        issue();
        wait_done(n);
`ifdef BSMM_SATURATE_EN
        chk("ext_r0", bus_s.result[0], 32'h7FFF_FFFF);
        chk("ext_sat0", bus_s.sat[0], 1);
        chk("ext_u_r0", bus_u.result[0], 32'h8000_0000);
`else
        chk("ext_r0", bus_s.result[0], 0);
        chk("ext_u_r0", bus_u.result[0], 0);
`endif
        cyc(1);

        // Unsigned wrap: 0xFFFFFFFF * 2.
        t_val = '0; t_coef = '0;
        t_val[0] = 32'hFFFF_FFFF; t_coef[0][0] = 8'd2;
        issue();
        wait_done(n);
`ifdef BSMM_SATURATE_EN
        chk("uns_r0", bus_u.result[0], 32'h7FFF_FFFF);
        chk("uns_sat0", bus_u.sat[0], 1);
`else
        chk("uns_r0", bus_u.result[0], 32'hFFFF_FFFE);
`endif
        chk("uns_signed_r0", bus_s.result[0], 32'hFFFF_FFFE);

        // Start during RUN is ignored.
        rand_in();
        ref_chan(3, 1'b1, pr, ps);
        issue();
        cyc(6);
        rand_in();
        t_start = 1'b1; cyc(1); t_start = 1'b0;
        wait_done(n);
        chk("ignored_start_r3", bus_s.result[3], pr);

        // Back-to-back: second start accepted in DONE, done period WIDTH+2.
        rand_in(); issue();
        rand_in(); issue();
        chk("b2b_done_first", bus_s.done, 1);
        cyc(1);
        wait_done(n);
        chk("b2b_period", n + 1, WIDTH + 2);
        cyc(1);

        // Reset at RUN bit 10 aborts the op.
        rand_in(); issue();
        cyc(1 + (WIDTH - 1 - 10));
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("midrst_result0", bus_s.result[0], 0);
        chk("midrst_ready", bus_s.ready, 1);
        cyc(WIDTH + 4);
        rand_in(); issue();
        wait_done(n);
        cyc(1);

        // Random traffic: random gaps, back-to-back and ignored pulses.
        for (int k = 0; k < 24; k++) begin
            rand_in();
            cyc($urandom_range(0, 2));
            issue();
            if ($urandom_range(0, 3) == 0) begin
                cyc(3);
                rand_in();
                t_start = 1'b1; cyc(1); t_start = 1'b0;
            end
            if ($urandom_range(0, 1) == 0) wait_done(n);
        end
        wait_done(n);
        cyc(4);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
